// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register ids, exception codes, field positions and write masks.
package cp0_regfile_pkg;

   typedef logic [4:0] cprid_t;

   localparam cprid_t CP0_BADVADDR = 5'd8;
   localparam cprid_t CP0_COUNT    = 5'd9;
   localparam cprid_t CP0_COMPARE  = 5'd11;
   localparam cprid_t CP0_STATUS   = 5'd12;
   localparam cprid_t CP0_CAUSE    = 5'd13;
   localparam cprid_t CP0_EPC      = 5'd14;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int unsigned ST_IE  = 0;
   localparam int unsigned ST_EXL = 1;
   localparam int unsigned ST_BEV = 22;
   localparam int unsigned CA_BD  = 31;
   localparam int unsigned CA_TI  = 30;

   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [31:0] STATUS_FIXED = 32'h0040_0000;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with optional divide-by-two and sticky timer interrupt.
module cp0_timer #(
   parameter int unsigned COUNT_DIV = 2
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic        i_count_we,
   input  logic        i_compare_we,
   input  logic        i_ti_clr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_count,
   output logic [31:0] o_compare,
   output logic        o_ti
);

   logic        r_tick;
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_ti;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_tick    <= 1'b0;
         r_count   <= 32'd0;
         r_compare <= 32'd0;
         r_ti      <= 1'b0;
      end else begin
         r_tick <= (COUNT_DIV == 1) ? 1'b1 : ~r_tick;
         if (i_count_we) begin
            r_count <= i_wdata;
         end else if (r_tick) begin
            r_count <= r_count + 32'd1;
         end
         if (i_compare_we) begin
            r_compare <= i_wdata;
         end
         // Clear from a Compare write beats a same-cycle match.
         if (i_ti_clr) begin
            r_ti <= 1'b0;
         end else if (r_count == r_compare) begin
            r_ti <= 1'b1;
         end
      end
   end

   assign o_count   = r_count;
   assign o_compare = r_compare;
   assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MTC0 writes, exception/ERET bookkeeping, bypassed reads and interrupt request.
module cp0_regfile
   import cp0_regfile_pkg::*;
#(
   parameter int unsigned COUNT_DIV = 2
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic [4:0]  i_rid,
   output logic [31:0] o_rdata,
   input  logic        i_wen,
   input  logic [4:0]  i_wid,
   input  logic [31:0] i_wdata,
   input  logic        i_exc_valid,
   input  logic [4:0]  i_exc_code,
   input  logic [31:0] i_exc_pc,
   input  logic        i_exc_bd,
   input  logic        i_exc_badv_we,
   input  logic [31:0] i_exc_badvaddr,
   input  logic        i_eret,
   input  logic [5:0]  i_ext_int,
   output logic        o_int_pending,
   output logic [31:0] o_epc,
   output logic        o_exl
);

   logic [31:0] r_badvaddr;
   logic [31:0] r_status;
   logic [31:0] r_epc;
   logic        r_cause_bd;
   logic [4:0]  r_cause_exc;
   logic [1:0]  r_ip_sw;
   logic [5:0]  r_ip_hw;

   logic [31:0] w_count;
   logic [31:0] w_compare;
   logic        w_ti;
   logic [31:0] w_status;
   logic [31:0] w_cause;
   logic [7:0]  w_ip;
   logic [31:0] w_cur;
   logic        w_wr_status;
   logic        w_wr_cause;
   logic        w_wr_epc;
   logic        w_wr_count;
   logic        w_wr_compare;

   assign w_wr_status  = i_wen && (i_wid == CP0_STATUS);
   assign w_wr_cause   = i_wen && (i_wid == CP0_CAUSE);
   assign w_wr_epc     = i_wen && (i_wid == CP0_EPC);
   assign w_wr_count   = i_wen && (i_wid == CP0_COUNT);
   assign w_wr_compare = i_wen && (i_wid == CP0_COMPARE);

   cp0_timer #(
      .COUNT_DIV (COUNT_DIV)
   ) u_timer (
      .i_clk        (i_clk),
      .i_resetn     (i_resetn),
      .i_count_we   (w_wr_count),
      .i_compare_we (w_wr_compare),
      .i_ti_clr     (w_wr_compare),
      .i_wdata      (i_wdata),
      .o_count      (w_count),
      .o_compare    (w_compare),
      .o_ti         (w_ti)
   );

   // r_status only ever holds writable bits; BEV is stitched in on read.
   assign w_status = (r_status & STATUS_WMASK) | STATUS_FIXED;
   assign w_ip     = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
   assign w_cause  = {r_cause_bd, w_ti, 14'd0, w_ip, 1'b0, r_cause_exc, 2'b00};

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_badvaddr  <= 32'd0;
         r_status    <= 32'd0;
         r_epc       <= 32'd0;
         r_cause_bd  <= 1'b0;
         r_cause_exc <= 5'd0;
         r_ip_sw     <= 2'd0;
         r_ip_hw     <= 6'd0;
      end else begin
         r_ip_hw <= i_ext_int;
         if (w_wr_cause) begin
            r_ip_sw <= i_wdata[9:8];
         end
         if (i_exc_valid) begin
            r_cause_exc <= i_exc_code;
            if (i_exc_badv_we) begin
               r_badvaddr <= i_exc_badvaddr;
            end
            // Nested exceptions keep the original return point.
            if (!r_status[ST_EXL]) begin
               r_epc      <= i_exc_bd ? (i_exc_pc - 32'd4) : i_exc_pc;
               r_cause_bd <= i_exc_bd;
            end
            r_status[ST_EXL] <= 1'b1;
         end else if (i_eret) begin
            r_status[ST_EXL] <= 1'b0;
         end else begin
            if (w_wr_status) begin
               r_status <= i_wdata & STATUS_WMASK;
            end
            if (w_wr_epc) begin
               r_epc <= i_wdata;
            end
         end
      end
   end

   always_comb begin
      w_cur = 32'd0;
      unique case (i_rid)
         CP0_BADVADDR: w_cur = r_badvaddr;
         CP0_COUNT:    w_cur = w_count;
         CP0_COMPARE:  w_cur = w_compare;
         CP0_STATUS:   w_cur = w_status;
         CP0_CAUSE:    w_cur = w_cause;
         CP0_EPC:      w_cur = r_epc;
         default:      w_cur = 32'd0;
      endcase
   end

   always_comb begin
      o_rdata = w_cur;
      if (i_wen && (i_wid == i_rid)) begin
         unique case (i_rid)
            CP0_STATUS: o_rdata = (w_cur & ~STATUS_WMASK) | (i_wdata & STATUS_WMASK);
            CP0_CAUSE:  o_rdata = (w_cur & ~CAUSE_WMASK) | (i_wdata & CAUSE_WMASK);
            CP0_COUNT, CP0_COMPARE, CP0_EPC: o_rdata = i_wdata;
            default:    o_rdata = w_cur;
         endcase
      end
   end

   assign o_int_pending = w_status[ST_IE] & ~w_status[ST_EXL] & (|(w_status[15:8] & w_ip));
   assign o_epc         = r_epc;
   assign o_exl         = r_status[ST_EXL];

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile (COUNT_DIV=2).
module tb_cp0_regfile;

   logic        clk;
   logic        resetn;
   logic [4:0]  rid;
   logic [31:0] rdata;
   logic        wen;
   logic [4:0]  wid;
   logic [31:0] wdata;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic        exc_badv_we;
   logic [31:0] exc_badvaddr;
   logic        eret;
   logic [5:0]  ext_int;
   logic        int_pending;
   logic [31:0] epc;
   logic        exl;

   int n_checks = 0;
   int n_errors = 0;

   cp0_regfile #(
      .COUNT_DIV (2)
   ) dut (
      .i_clk          (clk),
      .i_resetn       (resetn),
      .i_rid          (rid),
      .o_rdata        (rdata),
      .i_wen          (wen),
      .i_wid          (wid),
      .i_wdata        (wdata),
      .i_exc_valid    (exc_valid),
      .i_exc_code     (exc_code),
      .i_exc_pc       (exc_pc),
      .i_exc_bd       (exc_bd),
      .i_exc_badv_we  (exc_badv_we),
      .i_exc_badvaddr (exc_badvaddr),
      .i_eret         (eret),
      .i_ext_int      (ext_int),
      .o_int_pending  (int_pending),
      .o_epc          (epc),
      .o_exl          (exl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] id, output logic [31:0] v);
      rid = id;
      #1;
      v = rdata;
   endtask

   task automatic mtc0(input logic [4:0] id, input logic [31:0] d);
      wen = 1'b1;
      wid = id;
      wdata = d;
      tick();
      wen = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      logic [4:0]  ids [6];
      ids = '{5'd8, 5'd9, 5'd11, 5'd13, 5'd14, 5'd3};
      resetn = 1'b0;
      tick();
      tick();
      rd(5'd12, v);
      n_checks++;
      if (v !== 32'h0040_0000) begin
         $display("FAIL reset_status: got %h expected %h", v, 32'h0040_0000);
         n_errors++;
      end
      for (int i = 0; i < 6; i++) begin
         rd(ids[i], v);
         n_checks++;
         if (v !== 32'd0) begin
            $display("FAIL reset_reg%0d: got %h expected 0", ids[i], v);
            n_errors++;
         end
      end
      n_checks++;
      if ({int_pending, exl, epc} !== 34'd0) begin
         $display("FAIL reset_outputs: got pend=%b exl=%b epc=%h expected 0/0/0",
                  int_pending, exl, epc);
         n_errors++;
      end
      @(negedge clk);
      resetn = 1'b1;
      // Move Compare away so the reset-time Count==Compare match is cleared.
      tick();
      mtc0(5'd11, 32'hFFFF_0000);
   endtask

   task automatic test_status();
      logic [31:0] v;
      mtc0(5'd12, 32'hFFFF_FFFF);
      rd(5'd12, v);
      n_checks++;
      if (v !== 32'h0040_FF03 || exl !== 1'b1) begin
         $display("FAIL status_mask: got %h exl=%b expected 0040ff03 exl=1", v, exl);
         n_errors++;
      end
      ext_int = 6'b000001;
      rd(5'd13, v);
      n_checks++;
      if (v[10] !== 1'b0) begin
         $display("FAIL ip_delay: got IP2=%b expected 0", v[10]);
         n_errors++;
      end
      tick();
      rd(5'd13, v);
      n_checks++;
      if (v[10] !== 1'b1 || int_pending !== 1'b0) begin
         $display("FAIL ip_latch: got IP2=%b pend=%b expected 1/0", v[10], int_pending);
         n_errors++;
      end
      mtc0(5'd12, 32'h0000_FF01);
      n_checks++;
      if (int_pending !== 1'b1 || exl !== 1'b0) begin
         $display("FAIL int_pend: got pend=%b exl=%b expected 1/0", int_pending, exl);
         n_errors++;
      end
      ext_int = 6'd0;
      tick();
      n_checks++;
      if (int_pending !== 1'b0) begin
         $display("FAIL int_drop: got %b expected 0", int_pending);
         n_errors++;
      end
      mtc0(5'd3, 32'hDEAD_BEEF);
      rd(5'd3, v);
      n_checks++;
      if (v !== 32'd0) begin
         $display("FAIL unmapped: got %h expected 0", v);
         n_errors++;
      end
   endtask

   task automatic test_exception();
      logic [31:0] v;
      exc_valid = 1'b1;
      exc_code = 5'd4;
      exc_pc = 32'hBFC0_0100;
      exc_bd = 1'b1;
      exc_badv_we = 1'b1;
      exc_badvaddr = 32'h13;
      tick();
      exc_valid = 1'b0;
      exc_badv_we = 1'b0;
      rd(5'd14, v);
      n_checks++;
      if (v !== 32'hBFC0_00FC || epc !== 32'hBFC0_00FC || exl !== 1'b1) begin
         $display("FAIL exc_epc: got %h/%h exl=%b expected bfc000fc exl=1", v, epc, exl);
         n_errors++;
      end
      rd(5'd13, v);
      n_checks++;
      if (v !== 32'h8000_0010) begin
         $display("FAIL exc_cause: got %h expected 80000010", v);
         n_errors++;
      end
      rd(5'd8, v);
      n_checks++;
      if (v !== 32'h13) begin
         $display("FAIL exc_badv: got %h expected 00000013", v);
         n_errors++;
      end
      exc_valid = 1'b1;
      exc_code = 5'd8;
      exc_pc = 32'h100;
      exc_bd = 1'b0;
      tick();
      exc_valid = 1'b0;
      rd(5'd13, v);
      n_checks++;
      if (v !== 32'h8000_0020 || epc !== 32'hBFC0_00FC) begin
         $display("FAIL exc_nested: got cause=%h epc=%h expected 80000020 bfc000fc", v, epc);
         n_errors++;
      end
   endtask

   task automatic test_eret();
      logic [31:0] v;
      eret = 1'b1;
      tick();
      eret = 1'b0;
      n_checks++;
      if (exl !== 1'b0) begin
         $display("FAIL eret_exl: got %b expected 0", exl);
         n_errors++;
      end
      eret = 1'b1;
      exc_valid = 1'b1;
      exc_code = 5'd12;
      exc_pc = 32'h200;
      exc_bd = 1'b0;
      wen = 1'b1;
      wid = 5'd14;
      wdata = 32'h55;
      tick();
      eret = 1'b0;
      exc_valid = 1'b0;
      wen = 1'b0;
      rd(5'd13, v);
      n_checks++;
      if (exl !== 1'b1 || epc !== 32'h200 || v !== 32'h0000_0030) begin
         $display("FAIL exc_over_eret: got exl=%b epc=%h cause=%h expected 1 00000200 00000030",
                  exl, epc, v);
         n_errors++;
      end
      eret = 1'b1;
      wen = 1'b1;
      wid = 5'd12;
      wdata = 32'h0;
      tick();
      eret = 1'b0;
      wen = 1'b0;
      rd(5'd12, v);
      n_checks++;
      if (v !== 32'h0040_FF01) begin
         $display("FAIL eret_drops_mtc0: got %h expected 0040ff01", v);
         n_errors++;
      end
   endtask

   task automatic test_timer();
      logic [31:0] v;
      int n;
      mtc0(5'd12, 32'h0000_8001);
      mtc0(5'd11, 32'd4);
      mtc0(5'd9, 32'd0);
      n = 0;
      while (int_pending !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      rd(5'd13, v);
      n_checks++;
      if (int_pending !== 1'b1 || n < 8 || n > 9 || v[30] !== 1'b1 || v[15] !== 1'b1) begin
         $display("FAIL timer_fire: got pend=%b after %0d cycles cause=%h expected 1 in 8..9 TI=1",
                  int_pending, n, v);
         n_errors++;
      end
      mtc0(5'd11, 32'h100);
      rd(5'd13, v);
      n_checks++;
      if (v[30] !== 1'b0 || int_pending !== 1'b0) begin
         $display("FAIL ti_clear: got TI=%b pend=%b expected 0/0", v[30], int_pending);
         n_errors++;
      end
      mtc0(5'd9, 32'hFFFF_FFFF);
      n = 0;
      rd(5'd9, v);
      while (v === 32'hFFFF_FFFF && n < 4) begin
         tick();
         n++;
         rd(5'd9, v);
      end
      n_checks++;
      if (v !== 32'd0 || n > 2) begin
         $display("FAIL count_wrap: got %h after %0d cycles expected 00000000 within 2", v, n);
         n_errors++;
      end
   endtask

   task automatic test_bypass();
      logic [31:0] v;
      wen = 1'b1;
      wid = 5'd14;
      wdata = 32'h1234;
      rd(5'd14, v);
      n_checks++;
      if (v !== 32'h1234) begin
         $display("FAIL bypass_epc: got %h expected 00001234", v);
         n_errors++;
      end
      tick();
      wen = 1'b0;
      n_checks++;
      if (epc !== 32'h1234) begin
         $display("FAIL epc_write: got %h expected 00001234", epc);
         n_errors++;
      end
      wen = 1'b1;
      wid = 5'd12;
      wdata = 32'hFFFF_FFFF;
      rd(5'd12, v);
      wen = 1'b0;
      n_checks++;
      if (v !== 32'h0040_FF03) begin
         $display("FAIL bypass_status: got %h expected 0040ff03", v);
         n_errors++;
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      logic [31:0] st;
      logic [31:0] cnt;
      logic [31:0] cau;
      @(posedge clk);
      #3;
      resetn = 1'b0;
      rd(5'd12, st);
      rd(5'd9, cnt);
      rd(5'd13, cau);
      n_checks++;
      if (st !== 32'h0040_0000 || cnt !== 32'd0 || cau !== 32'd0 || epc !== 32'd0 ||
          exl !== 1'b0 || int_pending !== 1'b0) begin
         $display("FAIL async_reset: got st=%h cnt=%h cause=%h epc=%h exl=%b pend=%b expected reset",
                  st, cnt, cau, epc, exl, int_pending);
         n_errors++;
      end
      @(negedge clk);
      resetn = 1'b1;
      wen = 1'b1;
      wid = 5'd13;
      wdata = 32'hFFFF_FFFF;
      rd(5'd13, v);
      n_checks++;
      if (v !== 32'h0000_0300) begin
         $display("FAIL bypass_cause: got %h expected 00000300", v);
         n_errors++;
      end
      tick();
      wen = 1'b0;
      // Count and Compare are both 0 out of reset, so TI sets on the first edge.
      rd(5'd13, v);
      n_checks++;
      if (v !== 32'h4000_8300) begin
         $display("FAIL cause_after_reset: got %h expected 40008300", v);
         n_errors++;
      end
   endtask

   initial begin
      rid = 5'd0;
      wen = 1'b0;
      wid = 5'd0;
      wdata = 32'd0;
      exc_valid = 1'b0;
      exc_code = 5'd0;
      exc_pc = 32'd0;
      exc_bd = 1'b0;
      exc_badv_we = 1'b0;
      exc_badvaddr = 32'd0;
      eret = 1'b0;
      ext_int = 6'd0;
      resetn = 1'b0;
      test_reset();
      test_status();
      test_exception();
      test_eret();
      test_timer();
      test_bypass();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
